// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state type and load/store mask encoding
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam logic [1:0] MASK_B = 2'b00;
    localparam logic [1:0] MASK_H = 2'b01;
    localparam logic [1:0] MASK_W = 2'b10;
    localparam int         MASK_U = 2;

    // size 11 has no meaning of its own and is handled as a word
    function automatic logic is_word(input logic [1:0] sz);
        return sz[1];
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte enables, write replication, misalign detect and load extension
module mem_lane_align
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_rd_off,
    input  logic [2:0]  i_rd_mask,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_mis,
    output logic [31:0] o_ext
);
    logic        w_word;
    logic        w_half;
    logic        w_rd_word;
    logic        w_rd_half;
    logic        w_rd_sx;
    logic [31:0] w_sh;

    // request side: lane placement of the store and alignment test
    always_comb begin
        w_word  = is_word(i_size);
        w_half  = i_size == MASK_H;
        o_be    = w_word ? 4'hF : w_half ? (i_off[1] ? 4'hC : 4'h3) : 4'b0001 << i_off;
        o_wdata = w_word ? i_wdata : w_half ? {2{i_wdata[15:0]}} : {4{i_wdata[7:0]}};
        o_mis   = w_word ? |i_off : w_half & i_off[0];
    end

    // response side: shift the addressed lane down, then sign or zero extend
    always_comb begin
        w_rd_word = is_word(i_rd_mask[1:0]);
        w_rd_half = i_rd_mask[1:0] == MASK_H;
        w_rd_sx   = ~i_rd_mask[MASK_U];
        w_sh      = i_rdata >> {i_rd_off, 3'b000};
        o_ext     = w_rd_word ? w_sh
                  : w_rd_half ? {{16{w_rd_sx & w_sh[15]}}, w_sh[15:0]}
                  : {{24{w_rd_sx & w_sh[7]}}, w_sh[7:0]};
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory shared by fetch and data ports with starvation guard
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_kill,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_mask,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              stall_i,
    output logic              stall_d,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);
    localparam logic [3:0]        STREAK_MAX = 4'(MAX_D_STREAK);
    localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);

    arb_state_t  r_state;
    arb_state_t  w_next;
    logic        r_owner_d;
    logic        r_kill;
    logic        r_err;
    logic [3:0]  r_streak;
    logic [31:0] r_rdata;
    logic [1:0]  r_rd_off;
    logic [2:0]  r_rd_mask;
    logic        w_resp;
    logic        w_busy;
    logic        w_arb;
    logic        w_guard;
    logic        w_i_ok;
    logic        w_d_ok;
    logic        w_gnt_i;
    logic        w_gnt_d;
    logic        w_done;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ext;
    logic        w_mis;

    mem_lane_align u_align (
        .i_off     (d_addr[1:0]),
        .i_size    (d_mask[1:0]),
        .i_wdata   (d_wdata),
        .i_rd_off  (r_rd_off),
        .i_rd_mask (r_rd_mask),
        .i_rdata   (mem_rdata),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .o_mis     (w_mis),
        .o_ext     (w_ext)
    );

    // Arbitration runs in IDLE and RESP; the port being acked in RESP still shows its stale
    // request, so it is excluded. After a data response a still-high d_req keeps the fetch
    // waiting unless the streak guard has fired, which preserves data priority.
    always_comb begin
        w_resp  = r_state == RESP;
        w_busy  = (r_state == BUSY_I) | (r_state == BUSY_D);
        w_arb   = (r_state == IDLE) | w_resp;
        w_guard = r_streak == STREAK_MAX;
        w_i_ok  = w_arb & i_req & ~i_kill & ~(w_resp & ~r_owner_d);
        w_d_ok  = w_arb & d_req & ~(w_resp & r_owner_d);
        w_gnt_i = w_i_ok & (~d_req | w_guard);
        w_gnt_d = w_d_ok & ~w_gnt_i;
        w_done  = w_busy & mem_ack;
        w_next  = w_gnt_i ? BUSY_I
                : w_gnt_d ? (w_mis ? RESP : BUSY_D)
                : w_resp ? IDLE
                : w_done ? RESP
                : r_state;
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // memory-side request fields and the response capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            r_owner_d <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_rd_off  <= '0;
            r_rd_mask <= '0;
        end else if (w_gnt_i) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr & WORD_MASK;
            mem_be    <= 4'hF;
            mem_wdata <= '0;
            r_owner_d <= 1'b0;
            r_err     <= 1'b0;
        end else if (w_gnt_d) begin
            mem_req   <= ~w_mis;
            mem_we    <= d_we;
            mem_addr  <= d_addr & WORD_MASK;
            mem_be    <= w_be;
            mem_wdata <= w_wdata;
            r_owner_d <= 1'b1;
            r_err     <= w_mis;
            r_rdata   <= '0;
            r_rd_off  <= d_addr[1:0];
            r_rd_mask <= d_mask;
        end else if (w_done) begin
            mem_req   <= 1'b0;
            r_rdata   <= r_owner_d ? (mem_we ? '0 : w_ext) : mem_rdata;
        end
    end

    // consecutive data grants while a fetch waits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_streak <= '0;
        else      r_streak <= (~i_req | w_gnt_i) ? '0 : (w_gnt_d & ~w_guard) ? r_streak + 4'd1 : r_streak;
    end

    // a fetch killed in flight still completes on the bus but its ack is swallowed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_kill <= 1'b0;
        else      r_kill <= w_resp ? 1'b0 : r_kill | ((r_state == BUSY_I) & i_kill);
    end

    assign i_ack   = w_resp & ~r_owner_d & ~r_kill;
    assign d_ack   = w_resp & r_owner_d;
    assign i_rdata = i_ack ? r_rdata : '0;
    assign d_rdata = d_ack ? r_rdata : '0;
    assign d_err   = d_ack & r_err;
    assign stall_i = i_req & ~i_ack;
    assign stall_d = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with a behavioural wait-state memory
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } dexp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0, i_kill = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [2:0]  d_mask = '0;
    logic        i_ack, d_ack, d_err, stall_i, stall_d, mem_req, mem_we;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int          n_vec = 0;
    int          n_err = 0;
    int          mem_wait = 0;
    int          wcnt = 0;
    int          ack_cnt = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;
    logic        last_we;
    dexp_t       dq[$];
    logic [31:0] iq[$];
    byte         ack_log[$];

    mem_arbiter #(.ADDR_W(32), .MAX_D_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_mask(d_mask), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .stall_i(stall_i), .stall_d(stall_d),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] ld_exp(input logic [31:0] w, input logic [1:0] off, input logic [2:0] m);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        if (m[1:0] == MASK_B) return m[2] ? {24'h0, b} : {{24{b[7]}}, b};
        if (m[1:0] == MASK_H) return m[2] ? {16'h0, h} : {{16{h[15]}}, h};
        return w;
    endfunction

    function automatic logic misaligned(input logic [31:0] a, input logic [2:0] m);
        return (m[1:0] == MASK_H && a[0]) || (m[1] && a[1:0] != 2'b00);
    endfunction

    // memory: acks after mem_wait cycles of a held request, applies stores by byte enable
    always @(negedge clk) begin
        mem_ack = 1'b0;
        mem_rdata = 32'hDEADBEEF;
        if (rst && mem_req) begin
            if (wcnt >= mem_wait) begin
                logic [31:0] w;
                w = rd_word(mem_addr);
                mem_ack = 1'b1;
                mem_rdata = w;
                last_addr = mem_addr; last_be = mem_be; last_wdata = mem_wdata; last_we = mem_we;
                if (mem_we) begin
                    for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                    mem[mem_addr] = w;
                end
                ack_cnt++;
                wcnt = 0;
            end else wcnt++;
        end else wcnt = 0;
    end

    // scoreboard: every ack pops the oldest expectation of its port
    always @(negedge clk) begin
        if (rst && d_ack) begin
            ack_log.push_back(8'h44);
            if (dq.size() == 0) chk("d_ack_unexpected", 32'(d_ack), 0);
            else begin
                dexp_t e;
                e = dq.pop_front();
                chk("d_rdata", d_rdata, e.rd);
                chk("d_err", 32'(d_err), 32'(e.err));
            end
        end
        if (rst && i_ack) begin
            ack_log.push_back(8'h49);
            if (iq.size() == 0) chk("i_ack_unexpected", 32'(i_ack), 0);
            else chk("i_rdata", i_rdata, iq.pop_front());
        end
    end

    task automatic d_access(input logic we, input logic [31:0] a, input logic [2:0] m,
                            input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        int n;
        d_we = we; d_addr = a; d_mask = m; d_wdata = wd; d_req = 1'b1;
        dq.push_back('{exp_rd, exp_err});
        n = 0;
        do begin @(negedge clk); n++; end while (!d_ack && n < 50);
        if (!d_ack) chk("d_ack_timeout", 32'(d_ack), 1);
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic d_load(input logic [31:0] a, input logic [2:0] m);
        logic mis;
        mis = misaligned(a, m);
        d_access(1'b0, a, m, 32'h0, mis ? 32'h0 : ld_exp(rd_word(a & ~32'd3), a[1:0], m), mis);
    endtask

    task automatic i_fetch(input logic [31:0] a);
        int n;
        i_addr = a; i_req = 1'b1;
        iq.push_back(rd_word(a));
        n = 0;
        do begin @(negedge clk); n++; end while (!i_ack && n < 80);
        if (!i_ack) chk("i_ack_timeout", 32'(i_ack), 1);
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        string exp_s;
        int    base;
        logic  seen;
        int    n;
        mem[32'h40]  = 32'h00500093;
        mem[32'h200] = 32'h80010000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 32'({mem_req, mem_we, i_ack, d_ack, d_err, stall_i, stall_d, mem_be}), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", i_rdata | d_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // zero-wait fetch latency
        i_addr = 32'h40; i_req = 1'b1;
        iq.push_back(32'h00500093);
        @(negedge clk);
        chk("c0_mem_req", 32'(mem_req), 0);
        chk("c0_stall_i", 32'(stall_i), 1);
        @(negedge clk);
        chk("c1_mem_req", 32'(mem_req), 1);
        chk("c1_mem_addr", mem_addr, 32'h40);
        chk("c1_i_ack", 32'(i_ack), 0);
        @(negedge clk);
        chk("c2_i_ack", 32'(i_ack), 1);
        chk("c2_stall_i", 32'(stall_i), 0);
        @(posedge clk); #1;
        i_req = 1'b0;

        // data beats fetch when both arrive together
        ack_log.delete();
        fork
            i_fetch(32'h44);
            d_load(32'h100, {1'b0, MASK_W});
        join
        exp_s = "DI";
        for (int k = 0; k < 2; k++) chk("prio_order", 32'(k < ack_log.size() ? ack_log[k] : 8'h00), 32'(exp_s[k]));

        // starvation guard
        ack_log.delete();
        fork
            i_fetch(32'h300);
            begin
                for (int k = 0; k < 6; k++) d_load(32'h400 + 32'(4 * k), {1'b0, MASK_W});
            end
        join
        exp_s = "DDDDIDD";
        for (int k = 0; k < 7; k++) chk("streak_order", 32'(k < ack_log.size() ? ack_log[k] : 8'h00), 32'(exp_s[k]));

        // stores: lane placement
        d_access(1'b1, 32'h103, {1'b0, MASK_B}, 32'h000000AB, 32'h0, 1'b0);
        chk("sb_be", 32'(last_be), 32'h8);
        chk("sb_wdata", last_wdata, 32'hABABABAB);
        chk("sb_addr", last_addr, 32'h100);
        chk("sb_we", 32'(last_we), 1);
        d_access(1'b1, 32'h106, {1'b0, MASK_H}, 32'h00001234, 32'h0, 1'b0);
        chk("sh_be", 32'(last_be), 32'hC);
        chk("sh_wdata", last_wdata, 32'h12341234);
        d_load(32'h100, {1'b0, MASK_W});
        d_load(32'h104, {1'b0, MASK_W});

        // loads: extension
        d_access(1'b0, 32'h202, {1'b0, MASK_H}, 32'h0, 32'hFFFF8001, 1'b0);
        d_access(1'b0, 32'h202, {1'b1, MASK_H}, 32'h0, 32'h00008001, 1'b0);
        d_load(32'h203, {1'b0, MASK_B});
        d_load(32'h203, {1'b1, MASK_B});
        d_load(32'h201, {1'b0, MASK_B});
        d_load(32'h200, 3'b011);
        d_load(32'h201, {1'b0, MASK_H});

        // misaligned word: immediate error, no bus access
        base = ack_cnt;
        d_we = 1'b0; d_addr = 32'h101; d_mask = {1'b0, MASK_W}; d_req = 1'b1;
        dq.push_back('{32'h0, 1'b1});
        @(negedge clk);
        chk("mis_c0_ack", 32'(d_ack), 0);
        chk("mis_c0_stall", 32'(stall_d), 1);
        @(negedge clk);
        chk("mis_c1_ack", 32'(d_ack), 1);
        chk("mis_c1_err", 32'(d_err), 1);
        chk("mis_c1_stall", 32'(stall_d), 0);
        chk("mis_mem_req", 32'(mem_req), 0);
        @(posedge clk); #1;
        d_req = 1'b0;
        chk("mis_no_bus", 32'(ack_cnt - base), 0);

        // fetch held with kill in IDLE: no grant
        i_addr = 32'h60; i_req = 1'b1; i_kill = 1'b1;
        repeat (3) @(negedge clk);
        chk("kill_idle_req", 32'(mem_req), 0);
        @(posedge clk); #1;
        i_req = 1'b0; i_kill = 1'b0;

        // kill in flight with a slow memory
        mem_wait = 3;
        base = ack_cnt;
        i_addr = 32'h80; i_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_req && n < 20);
        chk("kill_mem_req", 32'(mem_req), 1);
        @(posedge clk); #1;
        i_kill = 1'b1;
        @(posedge clk); #1;
        i_kill = 1'b0; i_req = 1'b0;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); if (i_ack) seen = 1'b1; end
        chk("kill_no_iack", 32'(seen), 0);
        chk("kill_bus_done", 32'(ack_cnt - base), 1);
        chk("kill_mem_idle", 32'(mem_req), 0);
        i_fetch(32'h84);

        // asynchronous reset during a data access
        mem_wait = 6;
        d_we = 1'b0; d_addr = 32'h500; d_mask = {1'b0, MASK_W}; d_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_req && n < 20);
        chk("rst_mid_pre", 32'(mem_req), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_req", 32'(mem_req), 0);
        chk("rst_mid_ack", 32'(d_ack), 0);
        d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        mem_wait = 0;
        d_load(32'h500, {1'b0, MASK_W});
        i_fetch(32'h40);

        repeat (3) @(negedge clk);
        chk("dq_left", 32'(dq.size()), 0);
        chk("iq_left", 32'(iq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
